// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg -- shared definitions for the two-requester SRAM controller.
//   Default array geometry (WORDS/WIDTH/AW) and the controller state encoding.
package sram_ctrl_pkg;

  localparam int WORDS_DEFAULT = 8;
  localparam int WIDTH_DEFAULT = 8;
  localparam int AW_DEFAULT    = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    RECOVER = 3'd4
  } state_t;

endpackage

// File: rtl/sram_ctrl_rr_arbiter2.sv
// rr_arbiter2 -- two-way round-robin arbiter, purely combinational.
//   valid   in  2  request lines
//   pointer in  1  index of the requester granted last
//   grant   out 2  one-hot grant (all-zero when nobody requests)
// On a tie the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  // grant selection from request pattern and last-grant pointer
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl -- two-requester controller for a small bit-cell SRAM array.
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/ready/we     per-requester handshake and direction (bit i = requester i)
//   req_addr, req_wdata    per-requester address / write data slices
//   rsp_valid, rsp_rdata   one-cycle completion pulse to the owner, last read data
//   arr_sel/rdwrt/in/out   one-hot word select, cell mode (0 = write), cell data in/out
//   busy                   high whenever an access is in flight
// Every access takes IDLE -> SETUP -> WRITE|READ -> RECOVER (4 cycles in total).
// arr_sel and arr_in are loaded on the transfer edge and act as the captured
// address/data of the access; all array-side and response outputs are registers.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WORDS = WORDS_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_we,
  input  logic [2*AW-1:0]    req_addr,
  input  logic [2*WIDTH-1:0] req_wdata,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic [WORDS-1:0]   arr_sel,
  output logic               arr_rdwrt,
  output logic [WIDTH-1:0]   arr_in,
  input  logic [WIDTH-1:0]   arr_out,
  output logic               busy
);

  state_t             state;
  state_t             state_next;
  logic               pointer;
  logic               owner;
  logic               acc_we;
  logic [1:0]         grant;
  logic               transfer;
  logic               gnt_idx;
  logic [AW-1:0]      gnt_addr;
  logic [WIDTH-1:0]   gnt_wdata;
  logic [WORDS-1:0]   sel_next;
  logic               rdwrt_next;
  logic [WIDTH-1:0]   in_next;
  logic [WIDTH-1:0]   rdata_next;
  logic [1:0]         rsp_next;

  // Addresses beyond the array decode to an all-zero select.
  function automatic logic [WORDS-1:0] word_decode(input logic [AW-1:0] addr);
    logic [WORDS-1:0] sel;
    for (int i = 0; i < WORDS; i++) begin
      sel[i] = (addr == AW'(i));
    end
    return sel;
  endfunction

  rr_arbiter2 u_arb (
    .valid   (req_valid),
    .pointer (pointer),
    .grant   (grant)
  );

  assign gnt_idx   = grant[1];
  assign gnt_addr  = gnt_idx ? req_addr[2*AW-1:AW]     : req_addr[AW-1:0];
  assign gnt_wdata = gnt_idx ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
  assign transfer  = (state == IDLE) && (grant != 2'b00);
  assign busy      = (state != IDLE);

  // handshake: only the granted (hence valid) requester sees ready, only in IDLE
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE) begin
      req_ready = grant;
    end else begin
      req_ready = 2'b00;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      SETUP:   state_next = acc_we ? WRITE : READ;
      WRITE:   state_next = RECOVER;
      READ:    state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // next values of the registered array and response outputs
  always_comb begin
    sel_next   = arr_sel;
    rdwrt_next = 1'b1;
    in_next    = arr_in;
    rdata_next = rsp_rdata;
    rsp_next   = 2'b00;
    case (state)
      IDLE: begin
        if (transfer) begin
          sel_next = word_decode(gnt_addr);
          in_next  = gnt_wdata;
        end else begin
          sel_next = {WORDS{1'b0}};
        end
      end
      // entering WRITE drops the cell mode to write for exactly one cycle
      SETUP: rdwrt_next = ~acc_we;
      WRITE: rsp_next = owner ? 2'b10 : 2'b01;
      READ: begin
        rsp_next = owner ? 2'b10 : 2'b01;
        // an all-zero select means the address was out of range: return zero
        rdata_next = (|arr_sel) ? arr_out : {WIDTH{1'b0}};
      end
      RECOVER: sel_next = {WORDS{1'b0}};
      default: sel_next = {WORDS{1'b0}};
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // per-access bookkeeping: owner, direction and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer <= 1'b1;
      owner   <= 1'b0;
      acc_we  <= 1'b0;
    end else if (transfer) begin
      pointer <= gnt_idx;
      owner   <= gnt_idx;
      acc_we  <= req_we[gnt_idx];
    end
  end

  // registered array-side and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_sel   <= {WORDS{1'b0}};
      arr_rdwrt <= 1'b1;
      arr_in    <= {WIDTH{1'b0}};
      rsp_valid <= 2'b00;
      rsp_rdata <= {WIDTH{1'b0}};
    end else begin
      arr_sel   <= sel_next;
      arr_rdwrt <= rdwrt_next;
      arr_in    <= in_next;
      rsp_valid <= rsp_next;
      rsp_rdata <= rdata_next;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl -- self-checking bench for sram_ctrl.
//   Two instances share the request inputs: one with 8 words, one with 6 words,
//   each attached to a behavioural cell array. A transaction-level model tracks
//   the access phase (T+0..T+3), round-robin pointer and expected memory.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW    = 3;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_we;
  logic [2*AW-1:0]    req_addr;
  logic [2*WIDTH-1:0] req_wdata;

  logic [1:0] rdy8, rdy6, rv8, rv6;
  logic [7:0] rd8, rd6, in8, in6, out8, out6, sel8;
  logic [5:0] sel6;
  logic       rw8, rw6, busy8, busy6;

  logic       cells_clear;
  logic [7:0] cells8 [8];
  logic [7:0] cells6 [6];

  // observed outputs, indexed by instance (0 = 8 words, 1 = 6 words)
  logic [7:0] sel_o [2];
  logic [7:0] rd_o  [2];
  logic [7:0] in_o  [2];
  logic [1:0] rv_o  [2];
  logic [1:0] rdy_o [2];
  logic       rw_o  [2];
  logic       busy_o[2];
  assign sel_o[0] = sel8;  assign sel_o[1] = {2'b00, sel6};
  assign rd_o[0]  = rd8;   assign rd_o[1]  = rd6;
  assign in_o[0]  = in8;   assign in_o[1]  = in6;
  assign rv_o[0]  = rv8;   assign rv_o[1]  = rv6;
  assign rdy_o[0] = rdy8;  assign rdy_o[1] = rdy6;
  assign rw_o[0]  = rw8;   assign rw_o[1]  = rw6;
  assign busy_o[0] = busy8; assign busy_o[1] = busy6;

  always #5 clk = ~clk;

  sram_ctrl #(.WORDS(8), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy8), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv8), .rsp_rdata(rd8),
    .arr_sel(sel8), .arr_rdwrt(rw8), .arr_in(in8), .arr_out(out8), .busy(busy8));

  sram_ctrl #(.WORDS(6), .WIDTH(WIDTH), .AW(AW)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy6), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv6), .rsp_rdata(rd6),
    .arr_sel(sel6), .arr_rdwrt(rw6), .arr_in(in6), .arr_out(out6), .busy(busy6));

  // behavioural cell arrays: selected words latch arr_in while arr_rdwrt is low
  always @(posedge clk) begin
    if (cells_clear) begin
      for (int i = 0; i < 8; i++) cells8[i] <= 8'h00;
      for (int i = 0; i < 6; i++) cells6[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) if (!rw8 && sel8[i]) cells8[i] <= in8;
      for (int i = 0; i < 6; i++) if (!rw6 && sel6[i]) cells6[i] <= in6;
    end
  end

  // cell read port: OR of all selected words
  always_comb begin
    out8 = 8'h00;
    out6 = 8'h00;
    for (int i = 0; i < 8; i++) if (sel8[i]) out8 = out8 | cells8[i];
    for (int i = 0; i < 6; i++) if (sel6[i]) out6 = out6 | cells6[i];
  end

  // reference model state
  int         checks = 0;
  int         failures = 0;
  int         ph;          // cycles since the transfer of the current access, 0 = idle
  logic       m_ptr;
  int         m_owner;
  logic       m_we;
  int         m_addr;
  logic [7:0] m_wdata;
  logic [7:0] last_rd [2];
  logic [7:0] ref_mem [2][8];
  int         lim [2];

  typedef struct {
    int         r;
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] e8;
    logic [7:0] e6;
    logic [7:0] esel;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0;
    m_ptr = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
  endtask

  // one clock cycle: drive at the falling edge, check against the model, advance
  task automatic cycle(input logic [1:0] v, input logic [1:0] we, input logic [2:0] a0,
                       input logic [2:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    int         gi;
    logic [1:0] exp_rdy;
    logic [7:0] exp_sel;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    gi = (v == 2'b11) ? (m_ptr ? 0 : 1) : (v[1] ? 1 : 0);
    exp_rdy = (ph == 0 && v != 2'b00) ? (2'b01 << gi) : 2'b00;
    for (int k = 0; k < 2; k++) begin
      exp_sel = (ph != 0 && m_addr < lim[k]) ? (8'h01 << m_addr) : 8'h00;
      if (ph == 3 && !m_we) last_rd[k] = (m_addr < lim[k]) ? ref_mem[k][m_addr] : 8'h00;
      check("req_ready", 32'(rdy_o[k]), 32'(exp_rdy));
      check("busy", 32'(busy_o[k]), 32'(ph != 0));
      check("arr_sel", 32'(sel_o[k]), 32'(exp_sel));
      check("arr_rdwrt", 32'(rw_o[k]), 32'(!(ph == 2 && m_we)));
      check("rsp_valid", 32'(rv_o[k]), (ph == 3) ? (32'd1 << m_owner) : 32'd0);
      check("rsp_rdata", 32'(rd_o[k]), 32'(last_rd[k]));
      if (ph != 0) check("arr_in", 32'(in_o[k]), 32'(m_wdata));
    end
    if (ph == 0) begin
      if (v != 2'b00) begin
        m_owner = gi;
        m_ptr   = gi[0];
        m_we    = we[gi];
        m_addr  = (gi == 1) ? int'(a1) : int'(a0);
        m_wdata = (gi == 1) ? d1 : d0;
        for (int k = 0; k < 2; k++) if (m_we && m_addr < lim[k]) ref_mem[k][m_addr] = m_wdata;
        ph = 1;
      end
    end else begin
      ph = (ph == 3) ? 0 : ph + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
  endtask

  // one complete access from a single requester, with explicit expectations
  task automatic run_access(input vec_t t);
    logic [1:0] v;
    v = 2'b01 << t.r;
    cycle(v, {t.we, t.we}, t.a, t.a, t.d, t.d);
    check("acc_sel_t1", 32'(sel8), 32'(t.esel));
    idle_cycle();
    check("acc_rdwrt_t2", 32'(rw8), 32'(!t.we));
    idle_cycle();
    check("acc_rsp_t3", 32'(rv8), 32'(v));
    check("acc_rdata8_t3", 32'(rd8), 32'(t.e8));
    check("acc_rdata6_t3", 32'(rd6), 32'(t.e6));
    idle_cycle();
  endtask

  initial begin
    lim[0] = 8;
    lim[1] = 6;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) ref_mem[k][i] = 8'h00;
    model_reset();
    rst_n = 1'b0;
    cells_clear = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_sel", 32'(sel8), 32'd0);
    check("rst_rdwrt", 32'(rw8), 32'd1);
    check("rst_in", 32'(in8), 32'd0);
    check("rst_rsp", 32'(rv8), 32'd0);
    check("rst_rdata", 32'(rd8), 32'd0);
    rst_n = 1'b1;
    cells_clear = 1'b0;

    // write then read of word 3 by different requesters
    run_access('{0, 1'b1, 3'd3, 8'hA5, 8'h00, 8'h00, 8'h08});
    run_access('{1, 1'b0, 3'd3, 8'h00, 8'hA5, 8'hA5, 8'h08});

    // table of single accesses, including addresses beyond the 6-word array
    tbl[0] = '{0, 1'b1, 3'd7, 8'h3C, 8'hA5, 8'hA5, 8'h80};
    tbl[1] = '{1, 1'b0, 3'd7, 8'h00, 8'h3C, 8'h00, 8'h80};
    tbl[2] = '{0, 1'b1, 3'd0, 8'h11, 8'h3C, 8'h00, 8'h01};
    tbl[3] = '{1, 1'b0, 3'd0, 8'h00, 8'h11, 8'h11, 8'h01};
    tbl[4] = '{0, 1'b1, 3'd6, 8'hF0, 8'h11, 8'h11, 8'h40};
    tbl[5] = '{0, 1'b0, 3'd6, 8'h00, 8'hF0, 8'h00, 8'h40};
    tbl[6] = '{1, 1'b1, 3'd5, 8'h5A, 8'hF0, 8'h00, 8'h20};
    tbl[7] = '{1, 1'b0, 3'd5, 8'h00, 8'h5A, 8'h5A, 8'h20};
    for (int i = 0; i < 8; i++) run_access(tbl[i]);

    // both requesters valid continuously after reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11; req_we = 2'b00; req_addr = {3'd2, 3'd1};
    #1;
    for (int i = 0; i < 16; i++) begin
      check("rr_ready", 32'(rdy8),
            (i % 4 != 0) ? 32'd0 : (((i / 4) % 2 == 0) ? 32'd1 : 32'd2));
      cycle(2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00);
    end

    // reset while in WRITE aborts the access immediately
    cycle(2'b01, 2'b01, 3'd3, 3'd0, 8'hA5, 8'h00);
    idle_cycle();
    rst_n = 1'b0;
    #1;
    check("abort_sel", 32'(sel8), 32'd0);
    check("abort_rdwrt", 32'(rw8), 32'd1);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_rsp", 32'(rv8), 32'd0);
    model_reset();
    idle_cycle();
    idle_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle();
    run_access('{0, 1'b0, 3'd3, 8'h00, 8'hA5, 8'hA5, 8'h08});

    // randomized traffic, including requests withdrawn before being accepted
    for (int i = 0; i < 400; i++) begin
      cycle(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
            8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WORDS, default 8, number of words in the attached bit-cell array.
REQ-002 Parameter WIDTH, default 8, bits per word.
REQ-003 Parameter AW, default 3, address width; SHALL satisfy 2**AW >= WORDS.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  2  per-requester access request; bit i = requester i.
REQ-007 req_ready  out  2  per-requester accept; transfer when valid&ready on the same bit.
REQ-008 req_we  in  2  1 = write, 0 = read, per requester.
REQ-009 req_addr  in  2*AW  word address; requester i in slice [i*AW +: AW].
REQ-010 req_wdata  in  2*WIDTH  write data; requester i in slice [i*WIDTH +: WIDTH].
REQ-011 rsp_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-012 rsp_rdata  out  WIDTH  read data, valid with rsp_valid of a read.
REQ-013 arr_sel  out  WORDS  one-hot word select to array cells.
REQ-014 arr_rdwrt  out  1  cell mode: 1 = hold/read, 0 = write.
REQ-015 arr_in  out  WIDTH  data to array cells.
REQ-016 arr_out  in  WIDTH  stored data from selected word.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, WRITE, READ, RECOVER.
REQ-019 IDLE: req_ready SHALL be high only for the arbiter-granted requester, combinationally, and only when that requester's valid is high; all other states: req_ready = 0.
REQ-020 Arbitration SHALL be round-robin with a 1-bit last-grant pointer: both valid -> grant requester != pointer; one valid -> grant it; pointer updates to the granted index on each transfer.
REQ-021 On transfer, SHALL capture owner index, we, addr, wdata into internal registers and go IDLE->SETUP.
REQ-022 SETUP (T+1): arr_sel = one-hot(addr), arr_rdwrt = 1, arr_in = captured wdata; next WRITE if we else READ.
REQ-023 WRITE (T+2): arr_sel held, arr_rdwrt = 0, arr_in held; next RECOVER.
REQ-024 READ (T+2): arr_sel held, arr_rdwrt = 1; arr_out sampled into rsp_rdata register at end of cycle; next RECOVER.
REQ-025 RECOVER (T+3): arr_sel held, arr_rdwrt = 1, rsp_valid[owner] = 1 for this cycle only; next IDLE.
REQ-026 Fixed occupancy: 4 cycles per access including the IDLE transfer cycle; a new transfer SHALL be possible in the cycle after RECOVER.
REQ-027 rsp_rdata SHALL hold its last read value across writes and idle cycles.
REQ-028 addr >= WORDS: arr_sel SHALL be all-zero for the access, no cell written, read returns 0, rsp_valid still pulses.
REQ-029 arr_sel, arr_rdwrt, arr_in, rsp_valid, rsp_rdata SHALL be driven from registers (no combinational path from req_* inputs).
REQ-030 Requester deasserting valid before ready SHALL be ignored without side effects.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, pointer = 1 (requester 0 wins first tie), arr_sel = 0, arr_rdwrt = 1, arr_in = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0.
REQ-032 Reset during SETUP/WRITE/READ/RECOVER SHALL abort the access with no rsp_valid pulse; a write aborted in WRITE leaves that word's contents undefined.

Structure
REQ-033 Shared package SHALL hold the state enumeration and the WORDS/WIDTH/AW defaults.
REQ-034 Arbiter SHALL be a separate sub-module rr_arbiter2 (inputs valid[1:0], pointer; output one-hot grant).

Verification
REQ-035 Reset release, req0 write addr 3 data 0xA5 -> arr_sel = 0x08 T+1..T+3, arr_rdwrt = 0 only at T+2, rsp_valid[0] at T+3.
REQ-036 Then req1 read addr 3 -> rsp_valid[1] at T+3 with rsp_rdata = 0xA5; arr_rdwrt never 0.
REQ-037 Both valid continuously after reset -> grants alternate 0,1,0,1; transfers exactly 4 cycles apart.
REQ-038 rst_n asserted in WRITE cycle -> arr_sel = 0, arr_rdwrt = 1, busy = 0 immediately; no rsp_valid.
REQ-039 WORDS = 6, read addr 7 -> arr_sel = 0 throughout, rsp_rdata = 0, rsp_valid pulses at T+3.
